// File: rtl/dbg_disp_pkg.sv
// Shared types for the debug display snapshot path: snapshot record, FSM states,
// display page encodings and the page formatting helper.
package dbg_disp_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] if_addr;
    } snapshot_t;

    typedef enum logic [1:0] {
        ST_LIVE,
        ST_HOLD,
        ST_FROZEN
    } state_t;

    localparam logic [1:0] PAGE_COMPACT = 2'd0;
    localparam logic [1:0] PAGE_WDATA   = 2'd1;
    localparam logic [1:0] PAGE_ADDR    = 2'd2;
    localparam logic [1:0] PAGE_IF_ADDR = 2'd3;

    function automatic logic [31:0] page_word(input snapshot_t s, input logic [1:0] page);
        logic [31:0] w;
        case (page)
            PAGE_WDATA:   w = s.wdata;
            PAGE_ADDR:    w = s.addr;
            PAGE_IF_ADDR: w = s.if_addr;
            default:      w = {s.addr[21:18], s.addr[3:0], s.wdata[11:0], s.if_addr[11:0]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dbg_hist_ring.sv
// Circular history of captured snapshots; read port addresses entries by age
// (0 = newest), and the fill count saturates at DEPTH.
module dbg_hist_ring
    import dbg_disp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  snapshot_t                  wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_age,
    output snapshot_t                  rd_data,
    output logic [$clog2(DEPTH):0]     entries
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    snapshot_t        mem [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head    <= '0;
            entries <= '0;
        end else if (wr_en) begin
            mem[head] <= wr_data;
            head      <= head + IDX_W'(1);
            if (entries != FULL) begin
                entries <= entries + (IDX_W+1)'(1);
            end
        end
    end

    // head points at the next free slot, so the newest entry sits one behind it
    assign rd_ptr  = head - rd_age - IDX_W'(1);
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/seg_dbg_capture.sv
// Debug snapshot stage ahead of the 7-segment controller: captures bus writes,
// rate-limits live updates, and supports frozen browsing of recent history.
module seg_dbg_capture
    import dbg_disp_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dbus_req_i,
    input  logic                     dbus_w_en_i,
    input  logic                     dbus_ack_i,
    input  logic [31:0]              dbus_addr_i,
    input  logic [31:0]              dbus_wdata_i,
    input  logic                     if_req_i,
    input  logic                     if_ack_i,
    input  logic [31:0]              if_addr_i,
    input  logic                     freeze_i,
    input  logic                     step_i,
    input  logic [1:0]               page_sel_i,
    output logic [31:0]              disp_data_o,
    output logic                     disp_frozen_o,
    output logic [$clog2(DEPTH)-1:0] hist_idx_o,
    output logic [CNT_W-1:0]         capture_cnt_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned HC_W  = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic [HC_W-1:0]  hold_cnt, hold_n;
    logic             pending, pending_n;
    snapshot_t        shown, shown_n;
    snapshot_t        snap_new, ring_rd;
    logic [IDX_W-1:0] idx, idx_n, idx_step, rd_age;
    logic [IDX_W:0]   entries;
    logic [31:0]      last_if;
    logic             step_q, step_d, step_rise;
    logic [1:0]       page_q;
    logic             cap, fetch_hs, ring_wr;

    assign cap       = dbus_req_i & dbus_w_en_i & dbus_ack_i;
    assign fetch_hs  = if_req_i & if_ack_i;
    assign step_rise = step_q & ~step_d;
    assign ring_wr   = cap & ~freeze_i & (state != ST_FROZEN);

    always_comb begin
        snap_new.addr    = dbus_addr_i;
        snap_new.wdata   = dbus_wdata_i;
        snap_new.if_addr = fetch_hs ? if_addr_i : last_if;
    end

    assign idx_step = ((IDX_W+1)'(idx) + (IDX_W+1)'(1) >= entries) ? '0 : idx + IDX_W'(1);
    // The single read port serves age 0 everywhere except a frozen step
    assign rd_age   = (state == ST_FROZEN && freeze_i && step_rise) ? idx_step : '0;

    dbg_hist_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ring_wr),
        .wr_data (snap_new),
        .rd_age  (rd_age),
        .rd_data (ring_rd),
        .entries (entries)
    );

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        pending_n = pending;
        shown_n   = shown;
        idx_n     = idx;
        if (freeze_i) begin
            state_n = ST_FROZEN;
            if (state != ST_FROZEN) begin
                idx_n   = '0;
                shown_n = (entries == '0) ? '0 : ring_rd;
            end else if (step_rise && entries > (IDX_W+1)'(1)) begin
                idx_n   = idx_step;
                shown_n = ring_rd;
            end
        end else begin
            case (state)
                ST_FROZEN: begin
                    state_n   = ST_LIVE;
                    pending_n = 1'b0;
                    idx_n     = '0;
                    shown_n   = (entries == '0) ? '0 : ring_rd;
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        if (pending) begin
                            shown_n   = ring_rd;
                            pending_n = cap;
                            hold_n    = HOLD_RELOAD;
                        end else begin
                            state_n = ST_LIVE;
                        end
                    end else begin
                        hold_n = hold_cnt - HC_W'(1);
                        if (cap) begin
                            pending_n = 1'b1;
                        end
                    end
                end
                default: begin
                    if (cap) begin
                        shown_n = snap_new;
                        hold_n  = HOLD_RELOAD;
                        state_n = ST_HOLD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_LIVE;
            hold_cnt      <= '0;
            pending       <= 1'b0;
            shown         <= '0;
            idx           <= '0;
            last_if       <= '0;
            step_q        <= 1'b0;
            step_d        <= 1'b0;
            page_q        <= '0;
            disp_data_o   <= '0;
            capture_cnt_o <= '0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_n;
            pending     <= pending_n;
            shown       <= shown_n;
            idx         <= idx_n;
            step_q      <= step_i;
            step_d      <= step_q;
            page_q      <= page_sel_i;
            disp_data_o <= page_word(shown, page_q);
            if (fetch_hs) begin
                last_if <= if_addr_i;
            end
            if (cap && capture_cnt_o != '1) begin
                capture_cnt_o <= capture_cnt_o + CNT_W'(1);
            end
        end
    end

    assign disp_frozen_o = (state == ST_FROZEN);
    assign hist_idx_o    = idx;

endmodule

// File: tb/tb_seg_dbg_capture.sv
// Self-checking bench for seg_dbg_capture: directed vector table, async reset
// sequences, and randomized traffic against a queue-based behavioural model.
module tb_seg_dbg_capture;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dbus_req_i = 0, dbus_w_en_i = 0, dbus_ack_i = 0;
    logic [31:0] dbus_addr_i = '0, dbus_wdata_i = '0;
    logic        if_req_i = 0, if_ack_i = 0;
    logic [31:0] if_addr_i = '0;
    logic        freeze_i = 0, step_i = 0;
    logic [1:0]  page_sel_i = '0;

    logic [31:0] disp;
    logic        frz;
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic [31:0] sat_disp;
    logic        sat_frz;
    logic [1:0]  sat_idx;
    logic [3:0]  sat_cnt;

    always #5 clk = ~clk;

    seg_dbg_capture #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbus_req_i(dbus_req_i), .dbus_w_en_i(dbus_w_en_i), .dbus_ack_i(dbus_ack_i),
        .dbus_addr_i(dbus_addr_i), .dbus_wdata_i(dbus_wdata_i),
        .if_req_i(if_req_i), .if_ack_i(if_ack_i), .if_addr_i(if_addr_i),
        .freeze_i(freeze_i), .step_i(step_i), .page_sel_i(page_sel_i),
        .disp_data_o(disp), .disp_frozen_o(frz), .hist_idx_o(idx), .capture_cnt_o(cnt)
    );

    seg_dbg_capture #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .dbus_req_i(dbus_req_i), .dbus_w_en_i(dbus_w_en_i), .dbus_ack_i(dbus_ack_i),
        .dbus_addr_i(dbus_addr_i), .dbus_wdata_i(dbus_wdata_i),
        .if_req_i(if_req_i), .if_ack_i(if_ack_i), .if_addr_i(if_addr_i),
        .freeze_i(freeze_i), .step_i(step_i), .page_sel_i(page_sel_i),
        .disp_data_o(sat_disp), .disp_frozen_o(sat_frz), .hist_idx_o(sat_idx), .capture_cnt_o(sat_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ifa;
    } snap_t;

    snap_t       hist[$];
    int          mode;
    longint      cyc, expire;
    bit          pend, s1, s2;
    snap_t       m_shown;
    int          m_idx, m_cnt, m_cnt4;
    logic [31:0] m_last_if, m_disp;
    logic [1:0]  m_page;

    function automatic logic [31:0] pagef(input snap_t s, input logic [1:0] p);
        if (p == 2'd1) return s.wdata;
        if (p == 2'd2) return s.addr;
        if (p == 2'd3) return s.ifa;
        return {s.addr[21:18], s.addr[3:0], s.wdata[11:0], s.ifa[11:0]};
    endfunction

    task automatic model_reset();
        hist.delete();
        mode = 0; pend = 0; s1 = 0; s2 = 0;
        m_shown = '0; m_idx = 0; m_cnt = 0; m_cnt4 = 0;
        m_last_if = '0; m_disp = '0; m_page = '0;
        cyc = 0; expire = 0;
    endtask

    task automatic model_edge();
        snap_t newest, ns;
        bit    cap, fh, rise;
        int    prev_mode;
        cyc++;
        cap = dbus_req_i & dbus_w_en_i & dbus_ack_i;
        fh  = if_req_i & if_ack_i;
        ns.addr  = dbus_addr_i;
        ns.wdata = dbus_wdata_i;
        ns.ifa   = fh ? if_addr_i : m_last_if;
        newest = (hist.size() > 0) ? hist[0] : '0;
        rise = s1 && !s2;
        m_disp = pagef(m_shown, m_page);
        prev_mode = mode;
        if (freeze_i) begin
            if (mode != 2) begin
                mode = 2; m_idx = 0; m_shown = newest;
            end else if (rise && hist.size() > 1) begin
                m_idx = (m_idx + 1) % hist.size();
                m_shown = hist[m_idx];
            end
        end else if (mode == 2) begin
            mode = 0; pend = 0; m_idx = 0; m_shown = newest;
        end else if (mode == 1) begin
            if (cyc == expire) begin
                if (pend) begin
                    m_shown = newest; pend = cap; expire = cyc + HOLD;
                end else begin
                    mode = 0;
                end
            end else if (cap) begin
                pend = 1;
            end
        end else if (cap) begin
            m_shown = ns; expire = cyc + HOLD; mode = 1;
        end
        if (cap && !freeze_i && prev_mode != 2) begin
            hist.push_front(ns);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        if (fh) m_last_if = if_addr_i;
        if (cap && m_cnt < 65535) m_cnt++;
        if (cap && m_cnt4 < 15) m_cnt4++;
        s2 = s1; s1 = step_i; m_page = page_sel_i;
    endtask

    task automatic compare_all();
        chk("disp_data", disp, m_disp);
        chk("disp_frozen", 32'(frz), 32'(mode == 2));
        chk("hist_idx", 32'(idx), 32'(m_idx));
        chk("capture_cnt", 32'(cnt), 32'(m_cnt));
        chk("sat_disp", sat_disp, m_disp);
        chk("sat_frozen", 32'(sat_frz), 32'(mode == 2));
        chk("sat_idx", 32'(sat_idx), 32'(m_idx));
        chk("sat_cnt", 32'(sat_cnt), 32'(m_cnt4));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit frz_v, input bit stp, input logic [1:0] pg, input bit cap,
                         input logic [31:0] addr, input logic [31:0] wd, input bit fh,
                         input logic [31:0] ifa);
        freeze_i = frz_v; step_i = stp; page_sel_i = pg;
        dbus_req_i = cap; dbus_w_en_i = cap; dbus_ack_i = cap;
        dbus_addr_i = addr; dbus_wdata_i = wd;
        if_req_i = fh; if_ack_i = fh; if_addr_i = ifa;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_disp"}, disp, 32'h0);
        chk({tag, "_frozen"}, 32'(frz), 32'h0);
        chk({tag, "_idx"}, 32'(idx), 32'h0);
        chk({tag, "_cnt"}, 32'(cnt), 32'h0);
        chk({tag, "_sat_cnt"}, 32'(sat_cnt), 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          frz, stp;
        logic [1:0]  pg;
        bit          cap;
        logic [31:0] addr, wd;
        bit          fh;
        logic [31:0] ifa;
        int          reps;
        bit          chk;
        logic [31:0] e_disp;
        int          e_idx;
        bit          e_frz;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(bit frz_v, bit stp, logic [1:0] pg, bit cap, logic [31:0] addr,
                                logic [31:0] wd, bit fh, logic [31:0] ifa, int reps, bit c,
                                logic [31:0] e_disp, int e_idx, bit e_frz, int e_cnt);
        vec_t v;
        v.frz = frz_v; v.stp = stp; v.pg = pg; v.cap = cap; v.addr = addr; v.wd = wd;
        v.fh = fh; v.ifa = ifa; v.reps = reps; v.chk = c;
        v.e_disp = e_disp; v.e_idx = e_idx; v.e_frz = e_frz; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // live capture, page 0
        tbl.push_back(mk(0,0,0,0,0,0,1,32'h123,1,0,0,0,0,-1));
        tbl.push_back(mk(0,0,0,1,32'h0004_0010,32'hABC,0,0,1,1,32'h0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,32'h10ABC123,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,7,1,32'h10ABC123,0,0,-1));
        // hold rate-limit, page 1
        tbl.push_back(mk(0,0,1,1,32'h100,32'h1,0,0,1,1,32'h10ABC123,0,0,2));
        tbl.push_back(mk(0,0,1,1,32'h104,32'h2,0,0,1,1,32'h1,0,0,-1));
        tbl.push_back(mk(0,0,1,1,32'h108,32'h3,0,0,1,1,32'h1,0,0,4));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,5,1,32'h1,0,0,-1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,1,1,32'h1,0,0,-1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,1,1,32'h3,0,0,-1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,7,1,32'h3,0,0,-1));
        // fill with A..E, then freeze and step through history
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0,0,1,1,32'h300 + 32'(k),32'hA + 32'(k),0,0,1,0,0,0,0,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hA,0,1,9));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hE,0,1,-1));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,1,32'hE,0,1,-1));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,1,32'hE,1,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hD,1,1,-1));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,1,32'hD,1,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hD,2,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hC,2,1,-1));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,1,32'hC,2,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hC,3,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hB,3,1,-1));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,1,32'hB,3,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hB,0,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hE,0,1,-1));
        // captures while frozen, step once, then release
        tbl.push_back(mk(1,0,1,1,32'h500,32'h55,0,0,3,1,32'hE,0,1,12));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,1,32'hE,0,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hE,1,1,-1));
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,1,32'hD,1,1,-1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,1,1,32'hD,0,0,-1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,1,1,32'hE,0,0,-1));
        // simultaneous fetch + capture, page changes
        tbl.push_back(mk(0,0,3,1,32'h200,32'h77,1,32'hCAFE_F00D,1,1,32'hE,0,0,-1));
        tbl.push_back(mk(0,0,3,0,0,0,0,0,1,1,32'hCAFE_F00D,0,0,-1));
        tbl.push_back(mk(0,0,3,0,0,0,0,0,7,1,32'hCAFE_F00D,0,0,-1));
        tbl.push_back(mk(0,0,2,0,0,0,0,0,1,1,32'hCAFE_F00D,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,32'h200,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,32'h0007_700D,0,0,13));
        tbl.push_back(mk(1,0,0,1,32'h600,32'h66,0,0,3,1,32'h0007_700D,0,1,16));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,32'h0007_700D,0,0,16));

        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].frz, tbl[k].stp, tbl[k].pg, tbl[k].cap, tbl[k].addr, tbl[k].wd,
                  tbl[k].fh, tbl[k].ifa);
            for (int r = 0; r < tbl[k].reps; r++) tick();
            if (tbl[k].chk) begin
                chk($sformatf("row%0d_disp", k), disp, tbl[k].e_disp);
                chk($sformatf("row%0d_idx", k), 32'(idx), 32'(tbl[k].e_idx));
                chk($sformatf("row%0d_frozen", k), 32'(frz), 32'(tbl[k].e_frz));
                if (tbl[k].e_cnt >= 0)
                    chk($sformatf("row%0d_cnt", k), 32'(cnt), 32'(tbl[k].e_cnt));
            end
        end
        chk("sat_cnt_allones", 32'(sat_cnt), 32'hF);

        // async reset in the middle of HOLD
        drive(0,0,0,1,32'h1000,32'h5,0,0);
        tick();
        drive(0,0,0,0,0,0,0,0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_hold");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,0,0,1,32'h0004_0010,32'h123,0,0);
        tick();
        drive(0,0,0,0,0,0,0,0);
        tick();
        chk("post_reset_live", disp, 32'h1012_3000);
        repeat (HOLD) tick();

        // async reset in the middle of FROZEN; ring must come back empty
        drive(1,0,1,0,0,0,0,0);
        repeat (3) tick();
        chk("frozen_before_reset", 32'(frz), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_frozen");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("frozen_empty_ring", disp, 32'h0);
        drive(0,0,0,0,0,0,0,0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) freeze_i = ~freeze_i;
            if ($urandom_range(0, 2) == 0) step_i = ~step_i;
            if ($urandom_range(0, 9) == 0) page_sel_i = 2'($urandom_range(0, 3));
            dbus_req_i   = ($urandom_range(0, 9) < 7);
            dbus_w_en_i  = ($urandom_range(0, 9) < 7);
            dbus_ack_i   = ($urandom_range(0, 9) < 7);
            dbus_addr_i  = $urandom;
            dbus_wdata_i = $urandom;
            if_req_i     = $urandom_range(0, 1) == 1;
            if_ack_i     = $urandom_range(0, 1) == 1;
            if_addr_i    = $urandom;
            tick();
        end
        drive(0,0,0,0,0,0,0,0);
        repeat (2 * HOLD) tick();
        chk("sat_cnt_final", 32'(sat_cnt), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
